// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 stream controller.
// Holds the FSM encodings, the init ROM and the window/invert opcodes.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_POWER,
        ST_CMD_LOAD,
        ST_CMD_SHIFT,
        ST_IDLE,
        ST_DATA_LOAD,
        ST_DATA_SHIFT
    } state_t;

    typedef enum logic [1:0] {
        SRC_INIT,
        SRC_WIN,
        SRC_INV
    } cmd_src_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_GAP
    } tx_state_t;

    localparam int INIT_LEN     = 23;
    localparam int INIT_MUX_IDX = 10;
    localparam int WIN_LEN      = 6;

    localparam logic [7:0] OP_COL_ADDR  = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
    localparam logic [7:0] OP_NORMAL    = 8'hA6;
    localparam logic [7:0] OP_INVERT    = 8'hA7;

    // Listed from the last byte (index 22) down to the first (index 0).
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        8'hAF, 8'hA4, 8'h14, 8'h8D, 8'h20, 8'hDB, 8'h22, 8'hD9,
        8'h80, 8'hD5, 8'h00, 8'hD3, 8'h3F, 8'hA8, 8'hA1, 8'h40,
        8'hC8, 8'h00, 8'h20, 8'hA6, 8'h7F, 8'h81, 8'hAE
    };

    function automatic logic [7:0] window_byte(
        input logic [4:0] idx,
        input int         width,
        input int         pages
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            5'd0:    b = OP_COL_ADDR;
            5'd2:    b = 8'(width - 1);
            5'd3:    b = OP_PAGE_ADDR;
            5'd5:    b = 8'(pages - 1);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// One SPI byte: LOAD, 8 MSB-first bits with a CLK_DIV half-period, then a GAP.
// mosi changes on the falling sck edge; done is high in the last GAP cycle.
module spi_byte_tx
    import oled_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       tx_dc,
    output logic       done,
    output logic       sck,
    output logic       mosi,
    output logic       dc,
    output logic       cs
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    tx_state_t  state;
    logic [DW-1:0] div;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;

    assign done = (state == TX_GAP) && (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sck     <= 1'b1;
            mosi    <= 1'b0;
            dc      <= 1'b0;
            cs      <= 1'b1;
        end else begin
            unique case (state)
                TX_IDLE: begin
                    if (start) begin
                        state   <= TX_SHIFT;
                        div     <= '0;
                        bit_cnt <= '0;
                        shreg   <= tx_byte[6:0];
                        mosi    <= tx_byte[7];
                        dc      <= tx_dc;
                        cs      <= 1'b0;
                        sck     <= 1'b0;
                    end
                end
                TX_SHIFT: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else if (bit_cnt == 3'd7) begin
                            state <= TX_GAP;
                            cs    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            sck     <= 1'b0;
                            mosi    <= shreg[6];
                            shreg   <= {shreg[5:0], 1'b0};
                        end
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                TX_GAP: begin
                    if (div == DIV_LAST) begin
                        div   <= '0;
                        state <= TX_IDLE;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ssd1306_stream_ctrl.sv
// SSD1306 SPI controller: power-up reset, init ROM, then streamed frames.
// Optional OLED_INVERT_EN adds an invert input that sends A6/A7 from IDLE.
module ssd1306_stream_ctrl
    import oled_pkg::*;
#(
    parameter int CLK_DIV     = 1,
    parameter int RESET_DELAY = 100000000,
    parameter int WIDTH       = 128,
    parameter int PAGES       = 8,
    localparam int NBYTES     = WIDTH * PAGES,
    localparam int IW         = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic          clk,
    input  logic          rst,
`ifdef OLED_INVERT_EN
    input  logic          invert,
`endif
    input  logic          frame_start,
    input  logic [7:0]    data,
    input  logic          data_valid,
    output logic          data_ready,
    output logic [IW-1:0] byte_index,
    output logic          init_done,
    output logic          busy,
    output logic          frame_done,
    output logic          oled_sck,
    output logic          oled_mosi,
    output logic          oled_reset,
    output logic          oled_dc,
    output logic          oled_cs
);

    localparam int RW = $clog2(RESET_DELAY + 1);
    localparam logic [RW-1:0] PWR_LAST = RW'(RESET_DELAY - 1);

    state_t   state;
    cmd_src_t cmd_src;
    logic [4:0]    cmd_idx;
    logic [4:0]    last_idx;
    logic [RW-1:0] pwr_cnt;
    logic [1:0]    pwr_phase;
    logic [7:0]    cmd_byte;
    logic [IW-1:0] idx_next;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          tx_dc;
    logic          tx_done;
    logic          inv_now;

`ifdef OLED_INVERT_EN
    logic inv_state;
    assign inv_now = inv_state;
`else
    assign inv_now = 1'b0;
`endif

    always_comb begin
        cmd_byte = 8'h00;
        last_idx = 5'(INIT_LEN - 1);
        unique case (cmd_src)
            SRC_INIT: begin
                // The multiplex ratio follows the configured page count.
                if (cmd_idx == 5'(INIT_MUX_IDX))
                    cmd_byte = 8'(8 * PAGES - 1);
                else
                    cmd_byte = INIT_ROM[cmd_idx];
                last_idx = 5'(INIT_LEN - 1);
            end
            SRC_WIN: begin
                cmd_byte = window_byte(cmd_idx, WIDTH, PAGES);
                last_idx = 5'(WIN_LEN - 1);
            end
            SRC_INV: begin
                cmd_byte = inv_now ? OP_INVERT : OP_NORMAL;
                last_idx = 5'd0;
            end
            default: begin
                cmd_byte = 8'h00;
                last_idx = 5'd0;
            end
        endcase
    end

    assign idx_next = (byte_index == IW'(NBYTES - 1)) ? '0
                    : byte_index + IW'(1);

    assign tx_start = (state == ST_CMD_LOAD)
                   || (state == ST_DATA_LOAD && data_valid);
    assign tx_byte  = (state == ST_DATA_LOAD) ? data : cmd_byte;
    assign tx_dc    = (state == ST_DATA_LOAD);

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (tx_start),
        .tx_byte (tx_byte),
        .tx_dc   (tx_dc),
        .done    (tx_done),
        .sck     (oled_sck),
        .mosi    (oled_mosi),
        .dc      (oled_dc),
        .cs      (oled_cs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_POWER;
            cmd_src    <= SRC_INIT;
            cmd_idx    <= '0;
            pwr_cnt    <= '0;
            pwr_phase  <= '0;
            oled_reset <= 1'b1;
            data_ready <= 1'b0;
            byte_index <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b1;
`ifdef OLED_INVERT_EN
            inv_state  <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                ST_POWER: begin
                    // Three equal phases: high, low, high.
                    if (pwr_cnt == PWR_LAST) begin
                        pwr_cnt    <= '0;
                        pwr_phase  <= pwr_phase + 2'd1;
                        oled_reset <= (pwr_phase != 2'd0);
                        if (pwr_phase == 2'd2)
                            state <= ST_CMD_LOAD;
                    end else begin
                        pwr_cnt <= pwr_cnt + RW'(1);
                    end
                end
                ST_CMD_LOAD: state <= ST_CMD_SHIFT;
                ST_CMD_SHIFT: begin
                    if (tx_done) begin
                        if (cmd_idx == last_idx) begin
                            cmd_idx <= '0;
                            if (cmd_src == SRC_WIN) begin
                                state      <= ST_DATA_LOAD;
                                data_ready <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                if (cmd_src == SRC_INIT)
                                    init_done <= 1'b1;
                            end
                        end else begin
                            cmd_idx <= cmd_idx + 5'd1;
                            state   <= ST_CMD_LOAD;
                        end
                    end
                end
                ST_IDLE: begin
`ifdef OLED_INVERT_EN
                    if (invert != inv_state) begin
                        inv_state <= invert;
                        cmd_src   <= SRC_INV;
                        cmd_idx   <= '0;
                        state     <= ST_CMD_LOAD;
                        busy      <= 1'b1;
                    end else
`endif
                    if (frame_start) begin
                        cmd_src <= SRC_WIN;
                        cmd_idx <= '0;
                        state   <= ST_CMD_LOAD;
                        busy    <= 1'b1;
                    end
                end
                ST_DATA_LOAD: begin
                    if (data_valid) begin
                        data_ready <= 1'b0;
                        byte_index <= idx_next;
                        state      <= ST_DATA_SHIFT;
                    end
                end
                ST_DATA_SHIFT: begin
                    if (tx_done) begin
                        // byte_index has wrapped only after the last byte.
                        if (byte_index == '0) begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            state      <= ST_DATA_LOAD;
                            data_ready <= 1'b1;
                        end
                    end
                end
                default: state <= ST_POWER;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd1306_stream_ctrl.sv
// Self-checking bench for ssd1306_stream_ctrl with an SPI byte scoreboard.
// Define OLED_INVERT_EN for both bench and RTL to exercise the invert command.
module tb_ssd1306_stream_ctrl;

    localparam int CLK_DIV     = 2;
    localparam int RESET_DELAY = 10;
    localparam int WIDTH       = 4;
    localparam int PAGES       = 2;
    localparam int IW          = $clog2(WIDTH * PAGES);
    localparam int BYTE_CYC    = 17 * CLK_DIV + 1;
    localparam int FRAME_CYC   = (6 + WIDTH * PAGES) * BYTE_CYC;
    localparam int INIT_CYC    = 3 * RESET_DELAY + 23 * BYTE_CYC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic [7:0] data = 8'h00;
    logic data_valid = 1'b0;
`ifdef OLED_INVERT_EN
    logic invert = 1'b0;
`endif
    logic data_ready;
    logic [IW-1:0] byte_index;
    logic init_done, busy, frame_done;
    logic oled_sck, oled_mosi, oled_reset, oled_dc, oled_cs;

    logic [8:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int nbits = 0;
    logic prev_sck = 1'b1;
    logic [7:0] sh = 8'h00;
    logic stall_hold = 1'b0;

    logic [7:0] init_tab [23] = '{
        8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40,
        8'hA1, 8'hA8, 8'h0F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9,
        8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF
    };
    logic [7:0] win_tab [6] = '{8'h21, 8'h00, 8'h03, 8'h22, 8'h00, 8'h01};

    always #5 clk = ~clk;

    ssd1306_stream_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .RESET_DELAY (RESET_DELAY),
        .WIDTH       (WIDTH),
        .PAGES       (PAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef OLED_INVERT_EN
        .invert      (invert),
`endif
        .frame_start (frame_start),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .byte_index  (byte_index),
        .init_done   (init_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .oled_sck    (oled_sck),
        .oled_mosi   (oled_mosi),
        .oled_reset  (oled_reset),
        .oled_dc     (oled_dc),
        .oled_cs     (oled_cs)
    );

    // One clock step: decode SPI on the panel pins and drive the source.
    task automatic tick();
        logic [8:0] got;
        logic [8:0] want;
        @(negedge clk);
        if (rst || oled_cs !== 1'b0) begin
            nbits = 0;
        end else if (prev_sck === 1'b0 && oled_sck === 1'b1) begin
            sh = {sh[6:0], oled_mosi};
            nbits++;
            if (nbits == 8) begin
                nbits = 0;
                got = {oled_dc, sh};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spi_byte: got dc=%0b byte=%02h, expected none",
                             got[8], got[7:0]);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL spi_byte: got dc=%0b byte=%02h, expected dc=%0b byte=%02h",
                                 got[8], got[7:0], want[8], want[7:0]);
                    end
                end
            end
        end
        prev_sck = oled_sck;
        data = 8'h10 + 8'(byte_index);
        data_valid = !(stall_hold && byte_index == IW'(3));
    endtask

    task automatic push_frame();
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, win_tab[i]});
        for (int i = 0; i < WIDTH * PAGES; i++) exp_q.push_back({1'b1, 8'(8'h10 + i)});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({oled_sck, oled_mosi, oled_reset, oled_dc, oled_cs, data_ready,
             init_done, frame_done, busy} !== 9'b1_0_1_0_1_0_0_0_1) begin
            bad++;
            $display("FAIL reset_pins: got %b, expected 101010001",
                     {oled_sck, oled_mosi, oled_reset, oled_dc, oled_cs, data_ready,
                      init_done, frame_done, busy});
        end
        total++;
        if (byte_index !== '0) begin
            bad++;
            $display("FAIL reset_index: got %0d, expected 0", byte_index);
        end
    endtask

    task automatic test_init(input string tag);
        int errs;
        int done_at;
        logic e;
        for (int i = 0; i < 23; i++) exp_q.push_back({1'b0, init_tab[i]});
        rst = 1'b0;
        errs = 0;
        done_at = -1;
        for (int k = 1; k < 30; k++) begin
            tick();
            e = (k < 10 || k >= 20);
            if (oled_reset !== e || busy !== 1'b1 || init_done !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s power_phases: got %0d bad cycles, expected 0", tag, errs);
        end
        for (int k = 30; k <= 2000; k++) begin
            tick();
            if (init_done === 1'b1) begin
                done_at = k;
                break;
            end
        end
        total++;
        if (done_at != INIT_CYC) begin
            bad++;
            $display("FAIL %s init_done_cycle: got %0d, expected %0d", tag, done_at, INIT_CYC);
        end
        total++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s init_bytes: got %0d left busy=%b, expected 0 left busy=0",
                     tag, exp_q.size(), busy);
        end
    endtask

    task automatic test_frame();
        int n;
        int done_at;
        int pulses;
        logic busy_at;
        push_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL frame_busy_rise: got %b, expected 1", busy);
        end
        n = 1;
        pulses = 0;
        done_at = -1;
        busy_at = 1'bx;
        for (int i = 0; i < 1500; i++) begin
            tick();
            n++;
            if (frame_done === 1'b1) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = n;
                    busy_at = busy;
                end
            end
            if (done_at >= 0 && n >= done_at + 5) break;
        end
        total++;
        if (done_at != FRAME_CYC + 1) begin
            bad++;
            $display("FAIL frame_len: got %0d, expected %0d", done_at, FRAME_CYC + 1);
        end
        total++;
        if (pulses != 1 || busy_at !== 1'b0) begin
            bad++;
            $display("FAIL frame_done_pulse: got %0d pulses busy=%b, expected 1 pulse busy=0",
                     pulses, busy_at);
        end
        total++;
        if (exp_q.size() != 0 || byte_index !== '0 || init_done !== 1'b1) begin
            bad++;
            $display("FAIL frame_end: got left=%0d idx=%0d init=%b, expected 0 0 1",
                     exp_q.size(), byte_index, init_done);
        end
    endtask

    task automatic test_stall();
        int viol;
        int found;
        push_frame();
        stall_hold = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            tick();
            if (data_ready === 1'b1 && byte_index === IW'(3)) found = 1;
        end
        total++;
        if (found == 0) begin
            bad++;
            $display("FAIL stall_reach: got no wait at byte 3, expected one");
        end
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (oled_cs !== 1'b1 || oled_sck !== 1'b1 || data_ready !== 1'b1) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL stall_pins: got %0d bad cycles, expected 0", viol);
        end
        stall_hold = 1'b0;
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            tick();
            if (frame_done === 1'b1) found = 1;
        end
        total++;
        if (found == 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stall_frame: got done=%0d left=%0d, expected 1 0", found, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int first;
        int second;
        int busy_after;
        int idle_errs;
        push_frame();
        push_frame();
        frame_start = 1'b1;
        first = -1;
        second = -1;
        busy_after = 0;
        n = 0;
        for (int i = 0; i < 2000 && second < 0; i++) begin
            tick();
            n++;
            if (first >= 0 && n == first + 1) begin
                busy_after = busy;
                frame_start = 1'b0;
            end
            // short pulses while the second frame is running
            if (first >= 0 && (n == first + 100 || n == first + 250)) frame_start = 1'b1;
            else if (first >= 0 && n > first + 1) frame_start = 1'b0;
            if (frame_done === 1'b1) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        frame_start = 1'b0;
        total++;
        if (first < 0 || second - first != FRAME_CYC + 1 || busy_after != 1) begin
            bad++;
            $display("FAIL b2b_gap: got gap=%0d busy_after=%0d, expected gap=%0d busy_after=1",
                     second - first, busy_after, FRAME_CYC + 1);
        end
        idle_errs = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy !== 1'b0 || oled_cs !== 1'b1) idle_errs++;
        end
        total++;
        if (idle_errs != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_ignore: got %0d busy cycles left=%0d, expected 0 0",
                     idle_errs, exp_q.size());
        end
    endtask

`ifdef OLED_INVERT_EN
    task automatic test_invert();
        int n;
        int idle_at;
        int found;
        exp_q.push_back({1'b0, 8'hA7});
        push_frame();
        invert = 1'b1;
        frame_start = 1'b1;
        tick();
        n = 1;
        idle_at = -1;
        for (int i = 0; i < 200 && idle_at < 0; i++) begin
            tick();
            n++;
            if (busy === 1'b0) idle_at = n;
        end
        tick();
        frame_start = 1'b0;
        total++;
        if (idle_at != BYTE_CYC + 1) begin
            bad++;
            $display("FAIL invert_len: got %0d, expected %0d", idle_at, BYTE_CYC + 1);
        end
        found = 0;
        for (int i = 0; i < 1500 && found == 0; i++) begin
            tick();
            if (frame_done === 1'b1) found = 1;
        end
        total++;
        if (found == 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL invert_order: got done=%0d left=%0d, expected 1 0", found, exp_q.size());
        end
    endtask
`endif

    task automatic test_reset_mid();
        int found;
        push_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            tick();
            if (byte_index === IW'(2) && oled_dc === 1'b1 && oled_cs === 1'b0) found = 1;
        end
        total++;
        if (found == 0) begin
            bad++;
            $display("FAIL midrst_reach: got no data byte in flight, expected one");
        end
        rst = 1'b1;
        tick();
        total++;
        if ({oled_sck, oled_mosi, oled_reset, oled_dc, oled_cs, data_ready,
             init_done, frame_done, busy} !== 9'b1_0_1_0_1_0_0_0_1) begin
            bad++;
            $display("FAIL midrst_pins: got %b, expected 101010001",
                     {oled_sck, oled_mosi, oled_reset, oled_dc, oled_cs, data_ready,
                      init_done, frame_done, busy});
        end
        total++;
        if (byte_index !== '0) begin
            bad++;
            $display("FAIL midrst_index: got %0d, expected 0", byte_index);
        end
        exp_q.delete();
        tick();
        test_init("reinit");
    endtask

    initial begin
        test_reset();
        test_init("init");
        test_frame();
        test_stall();
        test_back_to_back();
`ifdef OLED_INVERT_EN
        test_invert();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
